// File: rtl/ser_frame_tx.sv
// ser_frame_tx: serial frame transmitter feeding the receiver/router stage.
//
// Accepts a request (port, count, payload) on a one-cycle start strobe while
// idle and shifts out one frame, MSB-first, one bit per clock:
//   START (0) | PORT (PORT_W bits) | COUNT (CNT_W bits) | DATA (N = count bits)
// The line idles high. done pulses in the first idle cycle after a frame, and
// a start in that same cycle is accepted, so back-to-back frames are separated
// by exactly one high bit.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-low reset
//   start     request strobe, accepted only while ready = 1
//   port_sel  destination port field, latched on accept
//   count     payload length N, latched on accept
//   data      payload, data[N-1:0] sent, upper bits ignored
//   serout    serial line output
//   ready     idle and able to accept a request
//   busy      frame in flight
//   done      one-cycle frame-completion pulse

module ser_frame_tx #(
    parameter int unsigned PORT_W = 2,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DATA_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [PORT_W-1:0] port_sel,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] data,
    output logic              serout,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    // Bit index counter must cover the widest field index: PORT_W-1, CNT_W-1
    // and N-1 (N < 2^CNT_W), so max(PORT_W, CNT_W) bits suffice.
    localparam int unsigned BIT_W = (PORT_W > CNT_W) ? PORT_W : CNT_W;

    localparam logic [BIT_W-1:0] PortLast = BIT_W'(PORT_W - 1);
    localparam logic [BIT_W-1:0] CntLast  = BIT_W'(CNT_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StPort,
        StCnt,
        StData
    } state_e;

    state_e              state_q, state_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;

    // Latched fields shifted so the bit currently addressed lands in bit 0;
    // avoids indexing narrow vectors with the wider shared counter.
    logic [PORT_W-1:0]   port_sh;
    logic [CNT_W-1:0]    cnt_sh;
    logic [DATA_W-1:0]   data_sh;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;

        port_sh = port_q >> bit_q;
        cnt_sh  = cnt_q >> bit_q;
        data_sh = data_q >> bit_q;

        serout  = 1'b1;
        ready   = 1'b0;
        busy    = 1'b1;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    port_d  = port_sel;
                    cnt_d   = count;
                    data_d  = data;
                    state_d = StStart;
                end
            end

            StStart: begin
                serout  = 1'b0;
                bit_d   = PortLast;
                state_d = StPort;
            end

            StPort: begin
                serout = port_sh[0];
                if (bit_q == '0) begin
                    bit_d   = CntLast;
                    state_d = StCnt;
                end else begin
                    bit_d = bit_q - BIT_W'(1);
                end
            end

            StCnt: begin
                serout = cnt_sh[0];
                if (bit_q == '0) begin
                    if (cnt_q != '0) begin
                        bit_d   = BIT_W'(cnt_q) - BIT_W'(1);
                        state_d = StData;
                    end else begin
                        // Empty payload: frame ends after the count field.
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    bit_d = bit_q - BIT_W'(1);
                end
            end

            StData: begin
                serout = data_sh[0];
                if (bit_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    bit_d = bit_q - BIT_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            bit_q   <= '0;
            port_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Testbench for ser_frame_tx: table-driven frames, hand-written corner cases
// (back-to-back with start held, asynchronous mid-frame reset) and random
// frames checked against a bit-list model of the frame format.

module tb_ser_frame_tx;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  port_sel;
    logic [3:0]  count;
    logic [14:0] data;
    logic        serout;
    logic        ready;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    ser_frame_tx #(
        .PORT_W(2),
        .CNT_W (4),
        .DATA_W(15)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .port_sel(port_sel),
        .count   (count),
        .data    (data),
        .serout  (serout),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  p;
        logic [3:0]  c;
        logic [14:0] d;
        logic [31:0] bits;  // expected frame, first bit at bits[len-1]
        int          len;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, what, act, exp);
        end
    endtask

    // Frame = start bit 0, port MSB-first, count MSB-first, data[N-1..0].
    function automatic void model(input logic [1:0] p, input logic [3:0] c,
                                  input logic [14:0] d, output logic [31:0] bits,
                                  output int len);
        bits = '0;
        len  = 0;
        bits = bits << 1;
        len++;
        for (int i = 1; i >= 0; i--) begin
            bits = (bits << 1) | 32'(p[i]);
            len++;
        end
        for (int i = 3; i >= 0; i--) begin
            bits = (bits << 1) | 32'(c[i]);
            len++;
        end
        for (int i = int'(c) - 1; i >= 0; i--) begin
            bits = (bits << 1) | 32'(d[i]);
            len++;
        end
    endfunction

    task automatic idle_check(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk(nm, "serout", 32'(serout), 32'd1);
            chk(nm, "ready", 32'(ready), 32'd1);
            chk(nm, "busy", 32'(busy), 32'd0);
            chk(nm, "done", 32'(done), 32'd0);
        end
    endtask

    // Called at a negedge. Presents the request, then checks every frame bit
    // and the done cycle. Without hold, start and the fields are scrambled
    // mid-frame (must be ignored) and start is dropped after the done sample;
    // with hold, start stays high so the next frame follows immediately.
    task automatic do_frame(input logic [1:0] p, input logic [3:0] c, input logic [14:0] d,
                            input logic [31:0] bits, input int len, input bit hold,
                            input string nm);
        start    = 1'b1;
        port_sel = p;
        count    = c;
        data     = d;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            chk(nm, $sformatf("serout[%0d]", i), 32'(serout), 32'(bits[len-1-i]));
            chk(nm, "busy", 32'(busy), 32'd1);
            chk(nm, "ready", 32'(ready), 32'd0);
            chk(nm, "done", 32'(done), 32'd0);
            if (!hold) begin
                start    = 1'($urandom);
                port_sel = 2'($urandom);
                count    = 4'($urandom);
                data     = 15'($urandom);
            end
        end
        @(negedge clock);
        chk(nm, "done_pulse", 32'(done), 32'd1);
        chk(nm, "done_serout", 32'(serout), 32'd1);
        chk(nm, "done_ready", 32'(ready), 32'd1);
        chk(nm, "done_busy", 32'(busy), 32'd0);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        logic [31:0] mbits;
        int          mlen;
        logic [1:0]  rp;
        logic [3:0]  rc;
        logic [14:0] rd;
        int          gap;

        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{p: 2'b11, c: 4'd3, d: 15'h0005, bits: 32'b0110011101, len: 10};
        tbl[1] = '{p: 2'b01, c: 4'd0, d: 15'h7FFF, bits: 32'b0010000, len: 7};
        tbl[2] = '{p: 2'b10, c: 4'd15, d: 15'h7FFF, bits: {10'd0, 7'b0101111, 15'h7FFF},
                   len: 22};
        tbl[3] = '{p: 2'b00, c: 4'd1, d: 15'h7FFE, bits: 32'b00000010, len: 8};

        // Reset state, checked before any clock edge.
        reset    = 1'b0;
        start    = 1'b0;
        port_sel = '0;
        count    = '0;
        data     = '0;
        #1;
        chk("reset", "serout", 32'(serout), 32'd1);
        chk("reset", "ready", 32'(ready), 32'd1);
        chk("reset", "busy", 32'(busy), 32'd0);
        chk("reset", "done", 32'(done), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle_check(5, "idle_after_reset");

        for (int k = 0; k < 4; k++) begin
            do_frame(tbl[k].p, tbl[k].c, tbl[k].d, tbl[k].bits, tbl[k].len, 1'b0,
                     $sformatf("tbl%0d", k));
            idle_check(1, $sformatf("tbl%0d_idle", k));
        end

        // start held high: two 22-bit frames, one high idle bit between them.
        do_frame(2'b10, 4'd15, 15'h7FFF, tbl[2].bits, 22, 1'b1, "b2b_first");
        do_frame(2'b10, 4'd15, 15'h7FFF, tbl[2].bits, 22, 1'b0, "b2b_second");
        idle_check(2, "b2b_idle");

        // Asynchronous reset in the middle of the data field.
        start    = 1'b1;
        port_sel = 2'b10;
        count    = 4'd8;
        data     = 15'h1234;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);  // start, port, count, two data bits shown
        #2;
        reset = 1'b0;
        #1;
        chk("midreset", "serout", 32'(serout), 32'd1);
        chk("midreset", "busy", 32'(busy), 32'd0);
        chk("midreset", "ready", 32'(ready), 32'd1);
        chk("midreset", "done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle_check(3, "after_midreset");
        model(2'b01, 4'd5, 15'h0016, mbits, mlen);
        do_frame(2'b01, 4'd5, 15'h0016, mbits, mlen, 1'b0, "post_reset_frame");
        idle_check(1, "post_reset_idle");

        // Random frames with random gaps (gap 0 = back-to-back).
        for (int k = 0; k < 25; k++) begin
            rp = 2'($urandom);
            rc = 4'($urandom);
            rd = 15'($urandom);
            model(rp, rc, rd, mbits, mlen);
            do_frame(rp, rc, rd, mbits, mlen, 1'b0, $sformatf("rnd%0d", k));
            gap = $urandom_range(0, 2);
            if (gap > 0) idle_check(gap, $sformatf("rnd%0d_gap", k));
        end
        idle_check(2, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ser_frame_tx.md
Name: ser_frame_tx

Overview:
- Upstream serializer that builds and drives the serial frame stream consumed by the serial receiver/router stage (its serin input).
- Accepts a parallel request (port, count, payload) on a single-cycle strobe and shifts out one frame, MSB-first, one bit per clock.
- The idle line is held high between frames.

Parameters:
- PORT_W, 2, width of the destination port field.
- CNT_W, 4, width of the payload length field.
- DATA_W, 15, payload register width; must be at least 2^CNT_W - 1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; the block is in reset while reset is 0.
- start  input  1  request strobe; accepted only when ready = 1.
- port_sel  input  PORT_W  destination port field, latched on accept.
- count  input  CNT_W  number of payload bits N (0..2^CNT_W-1), latched on accept.
- data  input  DATA_W  payload; bits data[N-1:0] are sent, upper bits ignored.
- serout  output  1  serial line; drives serin of the receiver stage.
- ready  output  1  high when a new request can be accepted.
- busy  output  1  high while a frame is being shifted.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state goes to IDLE immediately, without waiting for a clock edge.
  - Outputs: serout = 1, ready = 1, busy = 0, done = 0.
  - All latched fields are cleared.
  - A mid-frame reset aborts the frame; no done pulse is generated.
- Frame format, one bit per clock:
  - START bit: 0.
  - PORT: PORT_W bits, MSB first.
  - COUNT: CNT_W bits, MSB first.
  - DATA: N bits, data[N-1] first down to data[0].
  - Total frame length: 1 + PORT_W + CNT_W + N clocks.
- States: IDLE, START, PORT, CNT, DATA. A single down-counter, sized to max(PORT_W, CNT_W, CNT_W-bit N), tracks the bit index within the current field.
- IDLE:
  - Outputs: serout = 1, ready = 1, busy = 0.
  - If start = 1 at a rising edge: latch port_sel, count and data, and go to START. serout = 0 from that edge onward, i.e. one cycle of latency from accept.
- START: go to PORT after 1 cycle.
- PORT: go to CNT after PORT_W cycles.
- CNT:
  - After CNT_W cycles, go to DATA if N > 0.
  - If N = 0, go directly to IDLE; the frame is 7 bits with default parameters.
- DATA: go to IDLE after N cycles.
- In START, PORT, CNT and DATA: busy = 1, ready = 0.
- done:
  - Asserted for exactly the first IDLE cycle after a completed frame.
  - In that same cycle ready = 1 and serout = 1.
  - A start in that cycle is accepted, giving back-to-back frames separated by exactly one high idle bit.
- start is ignored while busy = 1. Inputs changing after accept do not affect the frame in flight.
- start held high continuously: a new frame begins on every done cycle.
- No X on serout at any time after reset is released.

Test Plan:
- Reset then idle 5 cycles -> serout = 1, ready = 1, busy = 0, done = 0 throughout.
- start with port_sel = 2'b11, count = 4'd3, data = 15'h0005 -> serout sequence 0,1,1,0,0,1,1,1,0,1 (10 bits); then serout = 1, one done pulse, busy high for exactly 10 cycles.
- start with port_sel = 2'b01, count = 0 -> serout 0,0,1,0,0,0,0 (7 bits); then done pulse; no data bits.
- start held high with count = 4'd15, data = 15'h7FFF -> two frames of 22 bits each, separated by exactly one high idle cycle; done pulses twice.
- Second start asserted mid-frame with different fields -> ignored; the first frame's bits are unchanged.
- reset driven low mid-DATA (off the clock edge) -> serout = 1 immediately, busy = 0, no done pulse; a fresh start after release gives a correct full frame.
